// File: rtl/cv32e40p_mult_fault_monitor.sv
// rtl/cv32e40p_mult_fault_monitor.sv - fault classifier for the triplicated multiplier voters
//
// Watches the voter disagreement flags, qualifies them with multiplier
// completion and classifies faults as transient (SUSPECT) or persistent.
// Purely observational: nothing here feeds back into the multiplier.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   enable_i           multiplier enable
//   mult_ready_i       voted multiplier ready
//   ex_ready_i         EX stage ready
//   result_faulty_i    per-bit disagreement mask of the result voter
//   ctrl_faulty_i      [0] multicycle, [1] mulh_active, [2] ready disagreement
//   clear_i            synchronous clear of counters, bitmap and state
//   fault_cnt_o        saturating count of faulty completions
//   done_cnt_o         saturating count of all completions
//   ctrl_fault_cnt_o   saturating count of enabled cycles with any ctrl fault
//   fault_bitmap_o     sticky OR of result masks over faulty completions
//   state_o            0=OK, 1=SUSPECT, 2=PERSISTENT
//   persistent_o       high while PERSISTENT
//   alarm_o            one-cycle pulse on entry to SUSPECT or PERSISTENT
module cv32e40p_mult_fault_monitor #(
  parameter int CNT_W          = 16,
  parameter int PERSIST_THRESH = 4,
  parameter int CLEAN_WINDOW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             mult_ready_i,
  input  logic             ex_ready_i,
  input  logic [31:0]      result_faulty_i,
  input  logic [2:0]       ctrl_faulty_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] fault_cnt_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic [CNT_W-1:0] ctrl_fault_cnt_o,
  output logic [31:0]      fault_bitmap_o,
  output logic [1:0]       state_o,
  output logic             persistent_o,
  output logic             alarm_o
);

  localparam int CF_W = $clog2(PERSIST_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CF_W-1:0]  CF_THRESH = CF_W'(PERSIST_THRESH);
  localparam logic [CF_W-1:0]  CF_LAST   = CF_W'(PERSIST_THRESH - 1);
  localparam logic [7:0]       CR_LAST   = 8'(CLEAN_WINDOW - 1);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_PERSIST = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [31:0]      bitmap_q, bitmap_d;
  logic [CF_W-1:0]  consec_q, consec_d;
  logic [7:0]       clean_q, clean_d;
  logic             alarm_q, alarm_d;
  logic             enter_alarm;

  logic done, faulty, clean, ctrl_evt;

  // Result flags only matter at completion; intermediate multicycle
  // values are not architectural, so 'done' gates them first.
  assign done     = enable_i & mult_ready_i & ex_ready_i;
  assign faulty   = done & ((|result_faulty_i) | ctrl_faulty_i[2]);
  assign clean    = done & ~faulty;
  assign ctrl_evt = enable_i & (|ctrl_faulty_i);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OK;
      fault_cnt_q <= '0;
      done_cnt_q  <= '0;
      ctrl_cnt_q  <= '0;
      bitmap_q    <= '0;
      consec_q    <= '0;
      clean_q     <= '0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fault_cnt_q <= fault_cnt_d;
      done_cnt_q  <= done_cnt_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
      bitmap_q    <= bitmap_d;
      consec_q    <= consec_d;
      clean_q     <= clean_d;
      alarm_q     <= alarm_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    fault_cnt_d = fault_cnt_q;
    done_cnt_d  = done_cnt_q;
    ctrl_cnt_d  = ctrl_cnt_q;
    bitmap_d    = bitmap_q;
    consec_d    = consec_q;
    clean_d     = clean_q;
    enter_alarm = 1'b0;

    if (clear_i) begin
      // Clear wins over any event in the same cycle.
      state_d     = ST_OK;
      fault_cnt_d = '0;
      done_cnt_d  = '0;
      ctrl_cnt_d  = '0;
      bitmap_d    = '0;
      consec_d    = '0;
      clean_d     = '0;
    end else begin
      if (done && done_cnt_q != CNT_MAX)    done_cnt_d  = done_cnt_q + 1'b1;
      if (faulty && fault_cnt_q != CNT_MAX) fault_cnt_d = fault_cnt_q + 1'b1;
      if (ctrl_evt && ctrl_cnt_q != CNT_MAX) ctrl_cnt_d = ctrl_cnt_q + 1'b1;
      if (faulty) bitmap_d = bitmap_q | result_faulty_i;

      // Run counters hold at their ceiling so PERSISTENT can run forever.
      if (faulty) begin
        consec_d = (consec_q == CF_THRESH) ? consec_q : consec_q + 1'b1;
        clean_d  = '0;
      end else if (clean) begin
        consec_d = '0;
        clean_d  = (clean_q == 8'hFF) ? clean_q : clean_q + 1'b1;
      end

      case (state_q)
        ST_OK: begin
          if (faulty) begin
            state_d     = (PERSIST_THRESH == 1) ? ST_PERSIST : ST_SUSPECT;
            enter_alarm = 1'b1;
          end
        end
        ST_SUSPECT: begin
          if (faulty && consec_q == CF_LAST) begin
            state_d     = ST_PERSIST;
            enter_alarm = 1'b1;
          end else if (clean && clean_q == CR_LAST) begin
            state_d  = ST_OK;
            consec_d = '0;
            clean_d  = '0;
          end
        end
        ST_PERSIST: ;
        default: state_d = ST_OK;
      endcase
    end
  end

  // Output logic. A transition directly after one that already pulsed is
  // folded into the pulse in flight so alarm_o never holds two cycles.
  always_comb begin
    alarm_d      = enter_alarm & ~alarm_q;
    persistent_o = (state_q == ST_PERSIST);
  end

  assign state_o          = state_q;
  assign alarm_o          = alarm_q;
  assign fault_cnt_o      = fault_cnt_q;
  assign done_cnt_o       = done_cnt_q;
  assign ctrl_fault_cnt_o = ctrl_cnt_q;
  assign fault_bitmap_o   = bitmap_q;

endmodule

// File: tb/tb_cv32e40p_mult_fault_monitor.sv
// tb/tb_cv32e40p_mult_fault_monitor.sv - directed self-checking bench for the multiplier fault monitor
module tb_cv32e40p_mult_fault_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, mr = 1'b0, er = 1'b0, clr = 1'b0;
  logic [31:0] res = '0;
  logic [2:0]  ctrl = '0;

  logic [15:0] fcnt, dcnt, ccnt;
  logic [31:0] bmap;
  logic [1:0]  st;
  logic        pers, alarm;

  logic [3:0]  fcnt4, dcnt4, ccnt4;
  logic [31:0] bmap4;
  logic [1:0]  st4;
  logic        pers4, alarm4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cv32e40p_mult_fault_monitor dut (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .mult_ready_i(mr), .ex_ready_i(er),
    .result_faulty_i(res), .ctrl_faulty_i(ctrl), .clear_i(clr),
    .fault_cnt_o(fcnt), .done_cnt_o(dcnt), .ctrl_fault_cnt_o(ccnt),
    .fault_bitmap_o(bmap), .state_o(st), .persistent_o(pers), .alarm_o(alarm)
  );

  cv32e40p_mult_fault_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .mult_ready_i(mr), .ex_ready_i(er),
    .result_faulty_i(res), .ctrl_faulty_i(ctrl), .clear_i(clr),
    .fault_cnt_o(fcnt4), .done_cnt_o(dcnt4), .ctrl_fault_cnt_o(ccnt4),
    .fault_bitmap_o(bmap4), .state_o(st4), .persistent_o(pers4), .alarm_o(alarm4)
  );

  // Inputs change 1 ns after a rising edge; outputs are read at that point too.
  task automatic cyc(input logic e, input logic m, input logic x,
                     input logic [31:0] r, input logic [2:0] c);
    en = e; mr = m; er = x; res = r; ctrl = c;
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({fcnt, dcnt, ccnt, bmap, st, pers, alarm} !== 83'h0) begin
      fails++; $display("FAIL reset_initial: got %h required 0", {fcnt, dcnt, ccnt, bmap, st, pers, alarm});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0100, 3'b001);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    tests++;
    if (st !== 2'd1) begin
      fails++; $display("FAIL reset_precondition: state %0d required 1", st);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({fcnt, dcnt, ccnt, bmap, st, pers, alarm} !== 83'h0) begin
      fails++; $display("FAIL reset_async: got %h required 0", {fcnt, dcnt, ccnt, bmap, st, pers, alarm});
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_fault();
    do_clear();
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0010, 3'b000);
    tests++;
    if ({st, alarm, fcnt, dcnt, bmap} !== {2'd1, 1'b1, 16'd1, 16'd1, 32'h10}) begin
      fails++; $display("FAIL single_fault: st=%0d alarm=%0d fcnt=%0d dcnt=%0d bmap=%h required 1 1 1 1 10",
                        st, alarm, fcnt, dcnt, bmap);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    tests++;
    if (alarm !== 1'b0 || st !== 2'd1) begin
      fails++; $display("FAIL single_fault_pulse: alarm=%0d st=%0d required 0 1", alarm, st);
    end
  endtask

  task automatic test_persistent();
    logic [3:0] exp_alarm;
    int alarms;
    exp_alarm = 4'b1001;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h1 << i, 3'b000);
      tests++;
      if (alarm !== exp_alarm[i]) begin
        fails++; $display("FAIL persist_alarm%0d: alarm=%0d required %0d", i, alarm, exp_alarm[i]);
      end
    end
    tests++;
    if ({st, pers, bmap, fcnt} !== {2'd2, 1'b1, 32'hF, 16'd4}) begin
      fails++; $display("FAIL persist_state: st=%0d pers=%0d bmap=%h fcnt=%0d required 2 1 f 4", st, pers, bmap, fcnt);
    end
    alarms = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 3'b000);
      if (alarm === 1'b1) alarms++;
    end
    tests++;
    if ({st, pers, dcnt} !== {2'd2, 1'b1, 16'd24} || alarms != 0) begin
      fails++; $display("FAIL persist_absorb: st=%0d pers=%0d dcnt=%0d alarms=%0d required 2 1 24 0", st, pers, dcnt, alarms);
    end
  endtask

  task automatic test_clean_window();
    int alarms;
    do_clear();
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_8000, 3'b000);
    alarms = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 3'b000);
      if (alarm === 1'b1) alarms++;
    end
    tests++;
    if (st !== 2'd1) begin
      fails++; $display("FAIL clean7_state: st=%0d required 1", st);
    end
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0001, 3'b000);
    tests++;
    if (st !== 2'd1 || alarm !== 1'b0) begin
      fails++; $display("FAIL clean_restart: st=%0d alarm=%0d required 1 0", st, alarm);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 3'b000);
      if (alarm === 1'b1) alarms++;
    end
    tests++;
    if (st !== 2'd1) begin
      fails++; $display("FAIL clean_restart7: st=%0d required 1", st);
    end
    cyc(1'b1, 1'b1, 1'b1, 32'h0, 3'b000);
    if (alarm === 1'b1) alarms++;
    tests++;
    if ({st, fcnt, dcnt} !== {2'd0, 16'd2, 16'd17} || alarms != 0) begin
      fails++; $display("FAIL clean_return: st=%0d fcnt=%0d dcnt=%0d alarms=%0d required 0 2 17 0", st, fcnt, dcnt, alarms);
    end
  endtask

  task automatic test_no_done();
    logic [31:0] xmask;
    xmask = 32'bx;
    do_clear();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'b001);
    tests++;
    if ({fcnt, dcnt, bmap, st, ccnt} !== {16'd0, 16'd0, 32'h0, 2'd0, 16'd10}) begin
      fails++; $display("FAIL no_done: fcnt=%0d dcnt=%0d bmap=%h st=%0d ccnt=%0d required 0 0 0 0 10",
                        fcnt, dcnt, bmap, st, ccnt);
    end
    cyc(1'b1, 1'b1, 1'b0, xmask, 3'b000);
    tests++;
    if ({bmap, st, ccnt} !== {32'h0, 2'd0, 16'd10}) begin
      fails++; $display("FAIL unknown_no_done: bmap=%h st=%0d ccnt=%0d required 0 0 10", bmap, st, ccnt);
    end
  endtask

  task automatic test_ctrl_ready_fault();
    do_clear();
    cyc(1'b1, 1'b1, 1'b1, 32'h0, 3'b100);
    tests++;
    if ({st, alarm, fcnt, ccnt, bmap} !== {2'd1, 1'b1, 16'd1, 16'd1, 32'h0}) begin
      fails++; $display("FAIL ctrl_ready_fault: st=%0d alarm=%0d fcnt=%0d ccnt=%0d bmap=%h required 1 1 1 1 0",
                        st, alarm, fcnt, ccnt, bmap);
    end
  endtask

  task automatic test_saturate_clear();
    do_clear();
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1, 32'h0, 3'b000);
    tests++;
    if (dcnt4 !== 4'd15 || dcnt !== 16'd20 || st4 !== 2'd0) begin
      fails++; $display("FAIL saturate: dcnt4=%0d dcnt=%0d st4=%0d required 15 20 0", dcnt4, dcnt, st4);
    end
    clr = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_00FF, 3'b100);
    clr = 1'b0;
    tests++;
    if ({fcnt, dcnt, ccnt, bmap, st, alarm, fcnt4, dcnt4, ccnt4, st4, alarm4} !== 99'h0) begin
      fails++; $display("FAIL clear_priority: got %h required 0",
                        {fcnt, dcnt, ccnt, bmap, st, alarm, fcnt4, dcnt4, ccnt4, st4, alarm4});
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_persistent();
    test_clean_window();
    test_no_done();
    test_ctrl_ready_fault();
    test_saturate_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/cv32e40p_mult_fault_monitor.md
Name: cv32e40p_mult_fault_monitor

Overview:
- Sits directly downstream of the triplicated multiplier and consumes the per-bit disagreement flags its voters produce.
- Qualifies those flags against multiplier completion and classifies faults as transient or persistent. Keeps saturating statistics and a sticky disagreement bitmap, and raises a one-cycle alarm to the controller/debug logic.
- Purely observational: never stalls or alters the multiplier datapath.

Parameters:
- CNT_W, 16, width of the saturating fault and completion counters.
- PERSIST_THRESH, 4, consecutive faulty completions that declare a persistent fault (legal range 1..2^CNT_W-1).
- CLEAN_WINDOW, 8, consecutive clean completions that return SUSPECT to OK (legal range 1..255).

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable_i, input, 1, multiplier enable (same signal driving the multiplier).
- mult_ready_i, input, 1, voted multiplier ready.
- ex_ready_i, input, 1, EX stage ready.
- result_faulty_i, input, 32, per-bit disagreement mask of the result voter.
- ctrl_faulty_i, input, 3, disagreement flags: [0] multicycle, [1] mulh_active, [2] ready.
- clear_i, input, 1, synchronous clear of counters, bitmap and state.
- fault_cnt_o, output, CNT_W, saturating count of faulty completions.
- done_cnt_o, output, CNT_W, saturating count of all completions.
- ctrl_fault_cnt_o, output, CNT_W, saturating count of cycles with any ctrl fault.
- fault_bitmap_o, output, 32, sticky OR of result_faulty_i over faulty completions.
- state_o, output, 2, 0=OK, 1=SUSPECT, 2=PERSISTENT.
- persistent_o, output, 1, high while state is PERSISTENT.
- alarm_o, output, 1, one-cycle pulse on entry to SUSPECT or PERSISTENT.

Behaviour:
- Reset values:
  - All counters, fault_bitmap_o and alarm_o are 0.
  - state_o is OK (0) and persistent_o is 0.
- Completion event: done = enable_i & mult_ready_i & ex_ready_i. It is evaluated every cycle, with at most one completion per cycle.
- Faulty completion: done & (|result_faulty_i | ctrl_faulty_i[2]). Result flags are ignored when done=0, because intermediate multicycle results are not architectural.
- ctrl_fault_cnt_o increments in every cycle where enable_i & |ctrl_faulty_i, independent of done.
- Counter rules:
  - All counters are registered, so the outputs update the cycle after the event.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Bitmap: on a faulty completion, fault_bitmap_o <= fault_bitmap_o | result_faulty_i. The bitmap is sticky until clear_i or reset.
- Internal counters:
  - consec_fault: width covers PERSIST_THRESH. Increments on a faulty completion and resets to 0 on a clean completion.
  - clean_run: 8 bits. Increments on a clean completion and resets to 0 on a faulty one.
- FSM, evaluated on done only:
  - OK: on a faulty completion -> SUSPECT, alarm pulse. If PERSIST_THRESH=1 -> PERSISTENT directly instead, with a single alarm pulse.
  - SUSPECT: on a faulty completion where consec_fault+1 == PERSIST_THRESH -> PERSISTENT, alarm pulse. When clean_run+1 == CLEAN_WINDOW -> OK, no pulse, internal counters zeroed.
  - PERSISTENT: absorbing. Only clear_i or reset exits. Counters and bitmap keep updating.
- alarm_o is registered, high exactly the cycle after the transition cycle, and never high two cycles in a row.
- clear_i priority and effect:
  - clear_i has priority over any same-cycle event; that cycle's event is discarded.
  - Next cycle: all counters 0, bitmap 0, state OK, alarm_o 0.
- Reset mid-operation: asynchronous, and immediately forces the reset values regardless of clock.
- Unknown ctrl_faulty_i or result_faulty_i while done=0 has no effect on state or bitmap.

Test Plan:
- Reset with rst_n low mid-run -> all outputs 0 and state_o=0 within the same cycle, before any clock edge.
- Single completion with result_faulty_i=32'h0000_0010 -> next cycle state_o=1, alarm_o=1 for one cycle, fault_cnt_o=1, done_cnt_o=1, fault_bitmap_o=32'h10.
- Four consecutive faulty completions with masks 1,2,4,8 (PERSIST_THRESH=4) -> alarm pulses after the 1st and 4th, state_o=2, persistent_o=1, fault_bitmap_o=32'hF. A further 20 clean completions leave state_o=2.
- One faulty completion, then 8 clean completions -> state_o returns to 0 after the 8th with no alarm. A faulty completion after 7 clean ones keeps state_o=1 and restarts clean_run.
- result_faulty_i=32'hFFFF_FFFF with done=0 (ex_ready_i=0) for 10 cycles, enable_i=1, ctrl_faulty_i=3'b001 -> fault_cnt_o=0, bitmap=0, state_o=0, ctrl_fault_cnt_o=10.
- CNT_W=4, 20 clean completions -> done_cnt_o saturates at 15. Then clear_i in the same cycle as a faulty completion -> next cycle all counters 0, state_o=0, alarm_o=0.
